// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : 2R/1W register file (x0 hardwired to zero) with a per-register
//            pending bit and popcount for decode/writeback hazard tracking.
//            Optional macro REGFILE_BYPASS_EN enables write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_pending_a,
  output logic                  rd_pending_b,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic                  rsv_ok,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   pending_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      pending_q, pending_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;

  logic wr_hit;
  logic rsv_set;
  logic rsv_same;
  logic wr_clr;
  logic fwd_a, fwd_b;

  always_comb begin
    rsv_ok   = rsv_en & ~flush & ~pending_q[rsv_addr];
    rsv_set  = rsv_ok & (rsv_addr != '0);
    wr_hit   = we & (wr_addr != '0);
    // A reserve to the register being written keeps its pending bit set,
    // whether or not the reserve itself is accepted this cycle.
    rsv_same = rsv_en & ~flush & wr_hit & (rsv_addr == wr_addr);
    wr_clr   = wr_hit & pending_q[wr_addr] & ~rsv_same;

    pending_d = pending_q;
    count_d   = count_q;
    if (flush) begin
      pending_d = '0;
      count_d   = '0;
    end else begin
      if (wr_clr)  pending_d[wr_addr]  = 1'b0;
      if (rsv_set) pending_d[rsv_addr] = 1'b1;
      count_d = count_q + {{ADDR_WIDTH{1'b0}}, rsv_set}
                        - {{ADDR_WIDTH{1'b0}}, wr_clr};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd_a = wr_hit & (wr_addr == rd_addr_a);
  assign fwd_b = wr_hit & (wr_addr == rd_addr_b);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  always_comb begin
    rd_data_a    = '0;
    rd_data_b    = '0;
    rd_pending_a = 1'b0;
    rd_pending_b = 1'b0;
    if (fwd_a) begin
      rd_data_a = wr_data;
    end else if (rd_addr_a != '0) begin
      rd_data_a    = regs_q[rd_addr_a];
      rd_pending_a = pending_q[rd_addr_a];
    end
    if (fwd_b) begin
      rd_data_b = wr_data;
    end else if (rd_addr_b != '0) begin
      rd_data_b    = regs_q[rd_addr_b];
      rd_pending_b = pending_q[rd_addr_b];
    end
  end

  assign pending_count = count_q;

endmodule

`default_nettype wire
